nanorv32_trace_serializer: RTL and testbench
============================================

# nanorv32_trace_serializer

Simulation and debug trace stage that sits directly downstream of the nanorv32 ASCII decoder. For each retired instruction it captures the PC, the 6-character mnemonic, the destination-register name and the written value. It buffers these records in a small FIFO and emits one newline-terminated ASCII line per record, byte by byte, over a valid/ready byte stream. The usual sink is a UART TX or a testbench log sink. The core is never stalled; records that arrive while the FIFO is full are dropped and counted.

## Interface
Parameters:
- FIFO_DEPTH, default 4: record FIFO depth; power of 2, ≥2.
- DROP_CNT_W, default 16: width of the drop counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- trace_valid  in  1  one retire event per cycle when high.
- trace_pc  in  32  PC of the retired instruction.
- trace_ascii_chain  in  48  mnemonic; 6 chars, first char in [47:40].
- trace_rd_ascii  in  32  rd name; 4 chars, first char in [31:24].
- trace_rd_we  in  1  instruction writes rd.
- trace_rd_data  in  32  value written to rd.
- tx_valid  out  1  tx_data holds a valid byte.
- tx_data  out  8  ASCII byte.
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready.
- drop_count  out  DROP_CNT_W  records dropped on FIFO full; saturating.
- busy  out  1  FIFO non-empty or a line is in progress.

## Operation
- Record (145 bits) = {pc, ascii_chain, rd_ascii, rd_we, rd_data}.
- It is pushed on a trace_valid edge if the FIFO is not full.
- Full is the registered count == FIFO_DEPTH. A push while full is dropped even if a pop occurs in the same cycle. On a drop, drop_count increments and saturates at all-ones.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into a shadow register, clear byte index idx, and go to EMIT.
  - EMIT: tx_valid=1. On handshake, idx++. On handshake of the last byte, go to IDLE.
- Line format by idx:
  - 0–7: PC hex nibbles, [31:28] first, lowercase 0-9a-f.
  - 8: space (0x20).
  - 9–14: mnemonic bytes, MSB first.
  - If rd_we=1: 15 space; 16–19 rd name; 20 '=' (0x3D); 21–28 rd_data hex, MSB nibble first; 29 '\n' (0x0A). Line length is 30 bytes.
  - If rd_we=0: 15 '\n'. Line length is 16 bytes.
- Hex conversion: nibble < 10 maps to 0x30+n; otherwise 0x57+n.

## Timing
- Reset values: tx_valid=0, tx_data=0x00, drop_count=0, busy=0. The FIFO is emptied and the FSM goes to IDLE.
- Reset mid-line abandons the line. tx_valid is low on the cycle after reset is sampled, and no partial-line bytes are emitted afterwards.
- Latency: trace_valid sampled at edge N → pop at edge N+1 → tx_valid=1 after edge N+1 with byte 0.
- Handshake: tx_data is stable while tx_valid && !tx_ready. tx_valid never drops without a handshake except on reset. There are no duplicated or skipped bytes.
- With tx_ready=1 continuously, one byte is transferred per cycle.
- Between consecutive lines there is exactly one IDLE cycle with tx_valid=0.
- A push and a pop in the same cycle with the FIFO not full are both performed, and the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

## Structure
- Shared include `nanorv32_trace_parameters.v` holds:
  - character constants: SPACE, EQ, NL, HEX_DIGIT_BASE;
  - line lengths: 16 and 30;
  - field index boundaries;
  - the record width.
- Sub-module `nanorv32_trace_fifo`: generic synchronous FIFO with parameters WIDTH and DEPTH and ports push/pop/full/empty/count, reset on rst_n.
- The serializer FSM, hex conversion function, and drop counter live in the top module.

## Test plan
- Single-record line: pc=0x00000100, mnemonic "ADDI  ", rd "a0  ", we=1, data=0x0000002A, tx_ready=1.
  - Response: exactly the 30 bytes "00000100 ADDI   a0  =0000002a\n".
  - First tx_valid appears 2 cycles after trace_valid.
  - busy falls after the '\n' handshake.
- No-write line: pc=0x80000004, mnemonic "SW    ", we=0.
  - Response: "80000004 SW    \n", 16 bytes.
- Backpressure: random tx_ready (50%) over 3 records.
  - tx_data is unchanged while stalled.
  - The byte stream equals the reference lines exactly.
  - Each line boundary is followed by one IDLE cycle.
- Overflow: tx_ready=0, 6 consecutive trace_valid, FIFO_DEPTH=4.
  - drop_count=1 (record 6 dropped).
  - After tx_ready=1: lines for records 1–5 in order.
- Saturation: DROP_CNT_W=4, FIFO held full, 20 further pushes.
  - drop_count=0xF and stays there.
- Reset mid-line: assert rst_n=0 for one cycle after 5 bytes of a 30-byte line.
  - tx_valid=0, drop_count=0, busy=0 next cycle.
  - A new record then produces its complete, correct line.

Source files
------------

// File: rtl/nanorv32_trace_serializer_pkg.sv
// Shared trace-line parameters for the nanorv32 trace serializer.
// Contents: ASCII character constants, the two line lengths, the byte-index
// boundaries of each field in a line, the record width/layout, and the
// serializer state type.
package nanorv32_trace_serializer_pkg;

  localparam logic [7:0] CH_SPACE       = 8'h20;
  localparam logic [7:0] CH_EQ          = 8'h3D;
  localparam logic [7:0] CH_NL          = 8'h0A;
  localparam logic [7:0] HEX_DIGIT_BASE = 8'h30;
  // 0x57 + 10 = 'a', so nibbles 10..15 map to lowercase a..f
  localparam logic [7:0] HEX_ALPHA_BASE = 8'h57;

  localparam logic [4:0] LINE_LEN_NOWR = 5'd16;
  localparam logic [4:0] LINE_LEN_WR   = 5'd30;

  localparam logic [4:0] IDX_PC_LAST    = 5'd7;
  localparam logic [4:0] IDX_SP0        = 5'd8;
  localparam logic [4:0] IDX_MN_FIRST   = 5'd9;
  localparam logic [4:0] IDX_MN_LAST    = 5'd14;
  localparam logic [4:0] IDX_SEP        = LINE_LEN_NOWR - 5'd1;
  localparam logic [4:0] IDX_RD_FIRST   = 5'd16;
  localparam logic [4:0] IDX_RD_LAST    = 5'd19;
  localparam logic [4:0] IDX_EQ         = 5'd20;
  localparam logic [4:0] IDX_DATA_FIRST = 5'd21;
  localparam logic [4:0] IDX_DATA_LAST  = 5'd28;
  localparam logic [4:0] IDX_NL_WR      = LINE_LEN_WR - 5'd1;

  localparam int REC_W = 145;

  typedef struct packed {
    logic [31:0] pc;
    logic [47:0] ascii_chain;
    logic [31:0] rd_ascii;
    logic        rd_we;
    logic [31:0] rd_data;
  } trace_rec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/nanorv32_trace_fifo.sv
// Generic synchronous FIFO with a registered occupancy count.
// Ports: clk, rst_n (sync, active-low), push/wdata, pop/rdata (head, valid
// while !empty), full (count == DEPTH), empty, count.
// A push while full or a pop while empty is ignored. DEPTH must be a power
// of 2 so the pointers wrap naturally.
module nanorv32_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nanorv32_trace_serializer.sv
// Trace serializer: buffers retired-instruction records and emits one ASCII
// line per record over a valid/ready byte stream.
// Ports: clk, rst_n (sync, active-low); trace_* retire-event inputs;
// tx_valid/tx_data/tx_ready byte stream; drop_count (saturating count of
// records lost to a full FIFO); busy (FIFO non-empty or line in progress).
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no line in progress; pops the FIFO head when one is available
// ST_EMIT | tx_valid high, stepping idx through the shadowed record's line
module nanorv32_trace_serializer
  import nanorv32_trace_serializer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trace_valid,
  input  logic [31:0]           trace_pc,
  input  logic [47:0]           trace_ascii_chain,
  input  logic [31:0]           trace_rd_ascii,
  input  logic                  trace_rd_we,
  input  logic [31:0]           trace_rd_data,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic                  busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return HEX_DIGIT_BASE + {4'h0, n};
    else           return HEX_ALPHA_BASE + {4'h0, n};
  endfunction

  // Byte i of the line for record r; fields are MSB-first within the record.
  function automatic logic [7:0] line_byte(input trace_rec_t r, input logic [4:0] i);
    logic [4:0] nsh;
    logic [5:0] bsh;
    logic [7:0] b;
    nsh = '0;
    bsh = '0;
    b   = 8'h00;
    if (i <= IDX_PC_LAST) begin
      nsh = 5'd28 - {i[2:0], 2'b00};
      b   = hex_char(r.pc[nsh +: 4]);
    end else if (i == IDX_SP0) begin
      b = CH_SPACE;
    end else if (i <= IDX_MN_LAST) begin
      bsh = 6'd40 - {3'(i - IDX_MN_FIRST), 3'b000};
      b   = r.ascii_chain[bsh +: 8];
    end else if (i == IDX_SEP) begin
      b = r.rd_we ? CH_SPACE : CH_NL;
    end else if (i <= IDX_RD_LAST) begin
      nsh = 5'd24 - {2'(i - IDX_RD_FIRST), 3'b000};
      b   = r.rd_ascii[nsh +: 8];
    end else if (i == IDX_EQ) begin
      b = CH_EQ;
    end else if (i <= IDX_DATA_LAST) begin
      nsh = 5'd28 - {3'(i - IDX_DATA_FIRST), 2'b00};
      b   = hex_char(r.rd_data[nsh +: 4]);
    end else if (i == IDX_NL_WR) begin
      b = CH_NL;
    end
    return b;
  endfunction

  trace_rec_t       rec_in;
  trace_rec_t       rec_head;
  trace_rec_t       shadow;
  ser_state_t       state;
  logic [4:0]       idx;
  logic [4:0]       last_idx;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [CNT_W-1:0] fifo_count;

  assign rec_in   = {trace_pc, trace_ascii_chain, trace_rd_ascii, trace_rd_we, trace_rd_data};
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
  assign last_idx = shadow.rd_we ? IDX_NL_WR : IDX_SEP;
  assign busy     = (state == ST_EMIT) || (fifo_count != '0);

  nanorv32_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (trace_valid),
    .wdata (rec_in),
    .pop   (fifo_pop),
    .rdata (rec_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      shadow     <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      drop_count <= '0;
    end else begin
      // Full is the registered count, so a same-cycle pop does not save the push.
      if (trace_valid && fifo_full && (drop_count != '1))
        drop_count <= drop_count + DROP_CNT_W'(1);

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shadow   <= rec_head;
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_data  <= line_byte(rec_head, 5'd0);
            state    <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (tx_ready) begin
            if (idx == last_idx) begin
              tx_valid <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              idx     <= idx + 5'd1;
              tx_data <= line_byte(shadow, idx + 5'd1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nanorv32_trace_serializer.sv
// Scoreboard bench for nanorv32_trace_serializer. Stimulus pushes the
// expected ASCII line (built with $sformatf) into a byte queue; a negedge
// monitor pops and compares on every handshake, and also checks stall
// stability and the idle gap after each newline. A second instance with a
// 4-bit drop counter covers saturation.
module tb_nanorv32_trace_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [47:0] trace_ascii_chain;
  logic [31:0] trace_rd_ascii;
  logic        trace_rd_we;
  logic [31:0] trace_rd_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [15:0] drop_count;
  logic        busy;

  logic        rst_n_sat;
  logic        trace_valid_sat;
  logic        tx_ready_sat;
  logic        tx_valid_sat;
  logic [7:0]  tx_data_sat;
  logic [3:0]  drop_count_sat;
  logic        busy_sat;

  always #5 clk = ~clk;

  nanorv32_trace_serializer #(.FIFO_DEPTH(4), .DROP_CNT_W(16)) u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .trace_valid       (trace_valid),
    .trace_pc          (trace_pc),
    .trace_ascii_chain (trace_ascii_chain),
    .trace_rd_ascii    (trace_rd_ascii),
    .trace_rd_we       (trace_rd_we),
    .trace_rd_data     (trace_rd_data),
    .tx_valid          (tx_valid),
    .tx_data           (tx_data),
    .tx_ready          (tx_ready),
    .drop_count        (drop_count),
    .busy              (busy)
  );

  nanorv32_trace_serializer #(.FIFO_DEPTH(4), .DROP_CNT_W(4)) u_sat (
    .clk               (clk),
    .rst_n             (rst_n_sat),
    .trace_valid       (trace_valid_sat),
    .trace_pc          (trace_pc),
    .trace_ascii_chain (trace_ascii_chain),
    .trace_rd_ascii    (trace_rd_ascii),
    .trace_rd_we       (trace_rd_we),
    .trace_rd_data     (trace_rd_data),
    .tx_valid          (tx_valid_sat),
    .tx_data           (tx_data_sat),
    .tx_ready          (tx_ready_sat),
    .drop_count        (drop_count_sat),
    .busy              (busy_sat)
  );

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         hs_count = 0;
  int         rdy_mode = 1;   // 0: ready low, 1: ready high, 2: random 50%

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c;
      c = s[i];
      exp_q.push_back(c);
    end
  endfunction

  // Reference line: "pppppppp MNEMON[ rdnm=dddddddd]\n"
  function automatic void exp_line(input logic [31:0] pc, input logic [47:0] mn,
                                   input logic [31:0] rd, input logic we,
                                   input logic [31:0] d);
    push_str($sformatf("%08h ", pc));
    for (int k = 5; k >= 0; k--) exp_q.push_back(mn[k*8 +: 8]);
    if (we) begin
      exp_q.push_back(8'h20);
      for (int k = 3; k >= 0; k--) exp_q.push_back(rd[k*8 +: 8]);
      push_str($sformatf("=%08h", d));
    end
    exp_q.push_back(8'h0A);
  endfunction

  task automatic send(input logic [31:0] pc, input logic [47:0] mn, input logic [31:0] rd,
                      input logic we, input logic [31:0] d, input bit dropped);
    trace_pc          = pc;
    trace_ascii_chain = mn;
    trace_rd_ascii    = rd;
    trace_rd_we       = we;
    trace_rd_data     = d;
    trace_valid       = 1'b1;
    if (!dropped) exp_line(pc, mn, rd, we, d);
    @(posedge clk); #1;
    trace_valid = 1'b0;
  endtask

  task automatic send_rand(input bit dropped);
    logic [47:0] mn;
    logic [31:0] rd;
    for (int k = 0; k < 6; k++) mn[k*8 +: 8] = 8'($urandom_range(65, 90));
    for (int k = 0; k < 4; k++) rd[k*8 +: 8] = 8'($urandom_range(97, 122));
    send($urandom, mn, rd, 1'($urandom_range(0, 1)), $urandom, dropped);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (n >= 3000) begin
      n_fail++;
      $display("FAIL %s: drain timeout, %0d bytes still expected, busy=%0b", name, exp_q.size(), busy);
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       tx_ready = 1'b0;
      1:       tx_ready = 1'b1;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard
  logic       prev_stall = 1'b0;
  logic       prev_nl    = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_nl    = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", {31'd0, tx_valid}, 32'd1);
        check("stall_data_stable", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (prev_nl) check("idle_gap_after_line", {31'd0, tx_valid}, 32'd0);
      prev_nl = 1'b0;
      if (tx_valid && tx_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL byte: got unexpected byte 0x%02h, expected none", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("byte", {24'd0, tx_data}, {24'd0, e});
        end
        prev_nl = (tx_data == 8'h0A);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst_n             = 1'b0;
    rst_n_sat         = 1'b0;
    trace_valid       = 1'b0;
    trace_valid_sat   = 1'b0;
    tx_ready_sat      = 1'b0;
    tx_ready          = 1'b1;
    trace_pc          = '0;
    trace_ascii_chain = '0;
    trace_rd_ascii    = '0;
    trace_rd_we       = 1'b0;
    trace_rd_data     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_drop_count", {16'd0, drop_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n     = 1'b1;
    rst_n_sat = 1'b1;
    @(posedge clk); #1;

    // Single record, latency and busy fall
    rdy_mode = 1;
    send(32'h0000_0100, "ADDI  ", "a0  ", 1'b1, 32'h0000_002A, 1'b0);
    check("lat_edge_n", {31'd0, tx_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_edge_n1", {31'd0, tx_valid}, 32'd1);
    check("busy_in_line", {31'd0, busy}, 32'd1);
    repeat (29) @(posedge clk);
    #1;
    check("busy_before_nl", {31'd0, busy}, 32'd1);
    check("left_before_nl", exp_q.size(), 32'd1);
    @(posedge clk); #1;
    check("busy_after_nl", {31'd0, busy}, 32'd0);
    check("left_after_nl", exp_q.size(), 32'd0);
    wait_idle("single_line");

    // No-write line
    send(32'h8000_0004, "SW    ", "zero", 1'b0, 32'hDEAD_BEEF, 1'b0);
    check("nowr_len_queued", exp_q.size(), 32'd16);
    wait_idle("nowrite_line");

    // Backpressure over 3 records
    rdy_mode = 2;
    repeat (3) send_rand(1'b0);
    wait_idle("backpressure");

    // Overflow: 1 shadow + 4 in FIFO, 6th dropped
    rdy_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) send_rand(i == 5);
    check("overflow_drop", {16'd0, drop_count}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("overflow_drop_hold", {16'd0, drop_count}, 32'd1);
    rdy_mode = 1;
    wait_idle("overflow_drain");
    check("overflow_drop_after", {16'd0, drop_count}, 32'd1);

    // Randomized rounds, never more than FIFO + shadow outstanding
    for (int r = 0; r < 8; r++) begin
      int n;
      rdy_mode = (r % 2 == 0) ? 2 : 1;
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        send_rand(1'b0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      wait_idle("random_round");
    end

    // Reset mid-line after 5 bytes
    rdy_mode = 1;
    base = hs_count;
    send(32'h1234_5678, "LUI   ", "t0  ", 1'b1, 32'hCAFE_F00D, 1'b0);
    for (int c = 0; c < 100 && hs_count < base + 5; c++) begin
      @(posedge clk); #1;
    end
    check("rst_mid_bytes_seen", hs_count - base, 32'd5);
    rst_n    = 1'b0;
    rdy_mode = 0;
    @(posedge clk); #1;
    check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("midrst_drop", {16'd0, drop_count}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    rst_n    = 1'b1;
    rdy_mode = 1;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_residue", {31'd0, tx_valid}, 32'd0);
    send(32'hFFFF_FFF0, "JAL   ", "ra  ", 1'b1, 32'h0000_0ABC, 1'b0);
    wait_idle("after_reset_line");

    // Saturation on the 4-bit counter instance
    trace_pc          = '0;
    trace_ascii_chain = '0;
    trace_rd_ascii    = '0;
    trace_rd_we       = 1'b0;
    trace_rd_data     = '0;
    trace_valid_sat   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("sat_no_drop_yet", {28'd0, drop_count_sat}, 32'd0);
    repeat (14) @(posedge clk);
    #1;
    check("sat_count_14", {28'd0, drop_count_sat}, 32'd14);
    repeat (6) @(posedge clk);
    #1;
    check("sat_count_15", {28'd0, drop_count_sat}, 32'd15);
    repeat (5) @(posedge clk);
    #1;
    check("sat_hold", {28'd0, drop_count_sat}, 32'd15);
    trace_valid_sat = 1'b0;
    check("sat_tx_valid", {31'd0, tx_valid_sat}, 32'd1);
    check("sat_tx_data", {24'd0, tx_data_sat}, 32'h30);
    check("sat_busy", {31'd0, busy_sat}, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
